// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - counter digits in, multiplexed 7-segment display bus out
interface seg7_scan_mux_if;
    logic [3:0] sec_val;
    logic [2:0] sec_val10;
    logic [3:0] min_val;
    logic [2:0] min_val10;
    logic       lz_blank;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_start;

    modport master (
        output sec_val, sec_val10, min_val, min_val10, lz_blank,
        input  seg, an, frame_start
    );

    modport slave (
        input  sec_val, sec_val10, min_val, min_val10, lz_blank,
        output seg, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - four-digit mm:ss scan multiplexer with per-frame snapshot and blanking gaps
module seg7_scan_mux #(
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    seg7_scan_mux_if.slave  dsp
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [PW-1:0] SHOW_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    SEG_INV   = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
    localparam logic [3:0]    AN_INV    = SEG_ACTIVE_LOW ? 4'hf : 4'h0;

    typedef enum logic {GAP, SHOW} state_t;

    state_t        state_q;
    logic [1:0]    idx_q;
    logic [PW-1:0] pcnt_q;
    logic [13:0]   snap_q, snap_d;
    logic          init_q;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          fs_q;
    logic          snap_load;
    logic [6:0]    dig_seg;
    logic          dig_blank;

    function automatic logic [6:0] decode(input logic [3:0] v, input logic [3:0] lim);
        logic [6:0] r;
        if (v > lim) begin
            r = 7'b1000000;
        end else begin
            case (v)
                4'd0:    r = 7'b0111111;
                4'd1:    r = 7'b0000110;
                4'd2:    r = 7'b1011011;
                4'd3:    r = 7'b1001111;
                4'd4:    r = 7'b1100110;
                4'd5:    r = 7'b1101101;
                4'd6:    r = 7'b1111101;
                4'd7:    r = 7'b0000111;
                4'd8:    r = 7'b1111111;
                default: r = 7'b1101111;
            endcase
        end
        return r;
    endfunction

    // Decode looks at the next snapshot so a SHOW entered on the load edge still sees fresh digits.
    always_comb begin
        snap_load = init_q || (state_q == SHOW && idx_q == 2'd3 && pcnt_q == SHOW_LAST);
        snap_d    = snap_load ? {dsp.min_val10, dsp.min_val, dsp.sec_val10, dsp.sec_val} : snap_q;
        dig_blank = dsp.lz_blank && idx_q == 2'd3 && snap_d[13:11] == 3'd0;
        case (idx_q)
            2'd0:    dig_seg = decode(snap_d[3:0], 4'd9);
            2'd1:    dig_seg = decode({1'b0, snap_d[6:4]}, 4'd5);
            2'd2:    dig_seg = decode(snap_d[10:7], 4'd9);
            default: dig_seg = decode({1'b0, snap_d[13:11]}, 4'd5);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= GAP;
            idx_q   <= 2'd0;
            pcnt_q  <= '0;
            snap_q  <= '0;
            init_q  <= 1'b1;
            seg_q   <= SEG_INV;
            an_q    <= AN_INV;
            fs_q    <= 1'b0;
        end else begin
            init_q <= 1'b0;
            snap_q <= snap_d;
            fs_q   <= snap_load;
            case (state_q)
                GAP: begin
                    if (pcnt_q == GAP_LAST) begin
                        state_q <= SHOW;
                        pcnt_q  <= '0;
                        if (dig_blank) begin
                            seg_q <= SEG_INV;
                            an_q  <= AN_INV;
                        end else begin
                            seg_q <= dig_seg ^ SEG_INV;
                            an_q  <= (4'b0001 << idx_q) ^ AN_INV;
                        end
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                default: begin
                    if (pcnt_q == SHOW_LAST) begin
                        state_q <= GAP;
                        pcnt_q  <= '0;
                        idx_q   <= idx_q + 2'd1;
                        seg_q   <= SEG_INV;
                        an_q    <= AN_INV;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign dsp.seg         = seg_q;
    assign dsp.an          = an_q;
    assign dsp.frame_start = fs_q;
endmodule
